rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rf_wb_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: write-back arbiter that merges unstallable ALU results with LSU results queued in a small FIFO.
// Define RF_WB_BYPASS_EN to build the decode-stage bypass lookup; otherwise the bypass outputs are tied to 0.
module rf_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  wR,
    output logic [31:0] wD,
    input  logic [4:0]  rR1,
    input  logic [4:0]  rR2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = (DEPTH > 3) ? 3 : 2;

    logic [4:0]       buf_rd_q   [DEPTH];
    logic [4:0]       buf_rd_d   [DEPTH];
    logic [31:0]      buf_data_q [DEPTH];
    logic [31:0]      buf_data_d [DEPTH];
    logic [DEPTH-1:0] buf_vld_q, buf_vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       wr_q, wr_d;
    logic [31:0]      wd_q, wd_d;
    logic             alu_win, buf_empty, head_vld, pop, lsu_acc, lsu_direct, push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (int'(ptr) == DEPTH - 1) ? '0 : ptr + 1'b1;
    endfunction

    // lsu_ready comes only from the count register, so it has no path from either valid input.
    assign lsu_ready = (count_q < CW'(DEPTH));
    assign stall_req = (count_q == CW'(DEPTH));
    assign we        = we_q;
    assign wR        = wr_q;
    assign wD        = wd_q;

    always_comb begin
        alu_win    = alu_valid && (alu_rd != 5'd0);
        buf_empty  = (count_q == '0);
        head_vld   = buf_vld_q[head_q];
        // A dead head is retired even while the ALU owns the write port.
        pop        = !buf_empty && (!alu_win || !head_vld);
        lsu_acc    = lsu_valid && lsu_ready;
        lsu_direct = lsu_acc && (lsu_rd != 5'd0) && !alu_win && buf_empty;
        push       = lsu_acc && (lsu_rd != 5'd0) && !lsu_direct;

        we_d = 1'b0;
        wr_d = wr_q;
        wd_d = wd_q;
        if (alu_win) begin
            we_d = 1'b1;
            wr_d = alu_rd;
            wd_d = alu_data;
        end else if (pop && head_vld) begin
            we_d = 1'b1;
            wr_d = buf_rd_q[head_q];
            wd_d = buf_data_q[head_q];
        end else if (lsu_direct) begin
            we_d = 1'b1;
            wr_d = lsu_rd;
            wd_d = lsu_data;
        end

        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;
        if (pop) buf_vld_d[head_q] = 1'b0;
        if (alu_win) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (buf_rd_q[i] == alu_rd) buf_vld_d[i] = 1'b0;
            end
        end
        // The incoming load is younger than the ALU write, so it is pushed live even on an rd match.
        if (push) begin
            buf_rd_d[tail_q]   = lsu_rd;
            buf_data_d[tail_q] = lsu_data;
            buf_vld_d[tail_q]  = 1'b1;
        end

        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            buf_vld_q <= '0;
            we_q      <= 1'b0;
            wr_q      <= '0;
            wd_q      <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            buf_vld_q <= buf_vld_d;
            we_q      <= we_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_rd_q   <= buf_rd_d;
        buf_data_q <= buf_data_d;
    end

`ifdef RF_WB_BYPASS_EN
    logic [4:0]    byp_r [2];
    logic [1:0]    byp_hit_v;
    logic [31:0]   byp_data_v [2];
    logic [PW-1:0] scan_p;

    assign byp_r[0]  = rR1;
    assign byp_r[1]  = rR2;
    assign byp_hit1  = byp_hit_v[0];
    assign byp_hit2  = byp_hit_v[1];
    assign byp_data1 = byp_data_v[0];
    assign byp_data2 = byp_data_v[1];

    // Scan oldest to youngest so the last match wins: write stage, head..tail, then this cycle's pick.
    always_comb begin
        scan_p = head_q;
        for (int p = 0; p < 2; p++) begin
            byp_hit_v[p]  = 1'b0;
            byp_data_v[p] = '0;
            scan_p        = head_q;
            if (byp_r[p] != 5'd0) begin
                if (we_q && (wr_q == byp_r[p])) begin
                    byp_hit_v[p]  = 1'b1;
                    byp_data_v[p] = wd_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (buf_vld_q[scan_p] && (buf_rd_q[scan_p] == byp_r[p])) begin
                        byp_hit_v[p]  = 1'b1;
                        byp_data_v[p] = buf_data_q[scan_p];
                    end
                    scan_p = ptr_inc(scan_p);
                end
                if (we_d && (wr_d == byp_r[p])) begin
                    byp_hit_v[p]  = 1'b1;
                    byp_data_v[p] = wd_d;
                end
            end
        end
    end
`else
    logic unused_byp_addr;
    assign unused_byp_addr = ^{rR1, rR2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios plus random traffic checked against a queue-based write-back model.
module tb_rf_wb_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        stall_req;
  logic        we;
  logic [4:0]  wR;
  logic [31:0] wD;
  logic [4:0]  rR1, rR2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;

  rf_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .stall_req(stall_req), .we(we), .wR(wR), .wD(wD),
    .rR1(rR1), .rR2(rR2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: pending loads in program order, dead ones still occupy a slot until drained
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;
  ent_t        model_q[$];
  logic        exp_we;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_byp(input logic [4:0] r, input logic n_we,
                                            input logic [4:0] n_wr, input logic [31:0] n_wd);
    if (r == 5'd0) return '0;
    if (n_we && n_wr == r) return {1'b1, n_wd};
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].live && model_q[i].rd == r) return {1'b1, model_q[i].data};
    if (exp_we && exp_wr == r) return {1'b1, exp_wd};
    return '0;
  endfunction

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    rR1 = '0; rR2 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    exp_we = 1'b0; exp_wr = '0; exp_wd = '0;
    check_eq("rst_we", we, 0);
    check_eq("rst_wR", wR, 0);
    check_eq("rst_wD", wD, 0);
    check_eq("rst_lsu_ready", lsu_ready, 1);
    check_eq("rst_stall", stall_req, 0);
  endtask

  // driver: one cycle, called at the falling edge; checks this cycle's outputs then advances the model
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic        alu_win, acc, direct, n_we;
    logic [4:0]  n_wr;
    logic [31:0] n_wd;
    logic [32:0] e1, e2;
    int          sz;
    check_eq("we", we, exp_we);
    if (exp_we) begin
      check_eq("wR", wR, exp_wr);
      check_eq("wD", wD, exp_wd);
    end
    sz = model_q.size();
    check_eq("lsu_ready", lsu_ready, sz < DEPTH);
    check_eq("stall_req", stall_req, sz == DEPTH);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    rR1 = r1; rR2 = r2;
    #1;
    alu_win = av && ard != 5'd0;
    acc     = lv && sz < DEPTH;
    direct  = acc && lrd != 5'd0 && !alu_win && sz == 0;
    n_we = 1'b0; n_wr = '0; n_wd = '0;
    if (alu_win) begin
      n_we = 1'b1; n_wr = ard; n_wd = ad;
    end else if (sz > 0 && model_q[0].live) begin
      n_we = 1'b1; n_wr = model_q[0].rd; n_wd = model_q[0].data;
    end else if (direct) begin
      n_we = 1'b1; n_wr = lrd; n_wd = ld;
    end
    e1 = model_byp(r1, n_we, n_wr, n_wd);
    e2 = model_byp(r2, n_we, n_wr, n_wd);
`ifdef RF_WB_BYPASS_EN
    check_eq("byp_hit1", byp_hit1, e1[32]);
    check_eq("byp_hit2", byp_hit2, e2[32]);
    if (e1[32]) check_eq("byp_data1", byp_data1, e1[31:0]);
    if (e2[32]) check_eq("byp_data2", byp_data2, e2[31:0]);
`else
    check_eq("byp_hit1_off", byp_hit1, 0);
    check_eq("byp_hit2_off", byp_hit2, 0);
    check_eq("byp_data1_off", byp_data1, 0);
    check_eq("byp_data2_off", byp_data2, 0);
    if (e1[32] && e2[32] && n_we) n_wr = n_wr;
`endif
    if (sz > 0 && (!alu_win || !model_q[0].live)) void'(model_q.pop_front());
    if (alu_win)
      for (int i = 0; i < model_q.size(); i++)
        if (model_q[i].rd == ard) model_q[i].live = 1'b0;
    if (acc && lrd != 5'd0 && !direct) model_q.push_back('{lrd, ld, 1'b1});
    exp_we = n_we; exp_wr = n_wr; exp_wd = n_wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_we"}, we, 1);
    check_eq({tag, "_wR"}, wR, rd);
    check_eq({tag, "_wD"}, wD, data);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // stimulus
  initial begin
    logic prev_stall, cur_stall, av, lv;
    rst_n = 1'b0;
    drive_idle();
    exp_we = 1'b0; exp_wr = '0; exp_wd = '0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // single ALU write
    step(1, 5, 32'h11, 0, 0, 0, 0, 0);
    expect_write("alu_only", 5, 32'h11);

    // ALU and load in the same cycle: load follows one cycle later
    step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    expect_write("dual_alu", 3, 32'hA);
    idle_step();
    expect_write("dual_lsu", 4, 32'hB);
    idle_step();

    // ALU busy while three loads are offered: buffer fills, then drains in order
    step(1, 1, 32'h101, 1, 10, 32'h1010, 0, 0);
    step(1, 2, 32'h102, 1, 11, 32'h1011, 0, 0);
    check_eq("full_stall", stall_req, 1);
    check_eq("full_ready", lsu_ready, 0);
    step(1, 6, 32'h106, 1, 12, 32'h1012, 0, 0);
    expect_write("full_alu", 6, 32'h106);
    idle_step();
    expect_write("drain0", 10, 32'h1010);
    idle_step();
    expect_write("drain1", 11, 32'h1011);
    idle_step();
    check_eq("drained_we", we, 0);

    // a buffered load overtaken by an ALU write to the same rd is never written
    step(1, 1, 32'h1, 1, 7, 32'h77, 0, 0);
    step(1, 7, 32'h99, 0, 0, 0, 0, 0);
    expect_write("stale_alu", 7, 32'h99);
    idle_step();
    check_eq("stale_skip_we", we, 0);
    idle_step();
    check_eq("stale_idle_we", we, 0);

    // bypass from a buffered load
    step(1, 1, 32'h1, 1, 9, 32'h55, 0, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0; rR1 = 5'd9; rR2 = 5'd0;
    #1;
`ifdef RF_WB_BYPASS_EN
    check_eq("byp9_hit1", byp_hit1, 1);
    check_eq("byp9_data1", byp_data1, 32'h55);
`else
    check_eq("byp9_hit1_off", byp_hit1, 0);
    check_eq("byp9_data1_off", byp_data1, 0);
`endif
    check_eq("byp0_hit2", byp_hit2, 0);
    idle_step();
    expect_write("byp_drain", 9, 32'h55);

    // reset with two entries buffered drops them
    step(1, 1, 32'h1, 1, 12, 32'hC, 0, 0);
    step(1, 2, 32'h2, 1, 13, 32'hD, 0, 0);
    check_eq("prerst_stall", stall_req, 1);
    do_reset();
    idle_step();
    check_eq("postrst_we0", we, 0);
    idle_step();
    check_eq("postrst_we1", we, 0);

    // random traffic with small rd range to force collisions
    prev_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cur_stall = stall_req;
      av = prev_stall ? 1'b0 : ($urandom_range(0, 99) < 55);
      lv = ($urandom_range(0, 99) < 60);
      step(av, 5'($urandom_range(0, 7)), $urandom, lv, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      prev_stall = cur_stall;
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
